// File: rtl/clk_divider_multi.sv
// clk_divider_multi: multi-channel programmable clock divider and tick generator.
// Each channel divides clkin by a runtime-programmable half-period. It drives a
// divided clock level and a one-cycle tick on every toggle of that level.
// Limit writes to a running channel are held in a shadow register. They take
// effect at the next wrap, so a half-period is never cut short.
// Optional feature macro: CLKDIV_SYNC_EN adds the sync_restart phase-alignment input.
module clk_divider_multi #(
    parameter int          CHANNELS      = 4,
    parameter int          CNT_W         = 32,
    parameter int unsigned DEFAULT_LIMIT = 25000000,
    parameter int          CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] clken,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_limit,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_restart,
`endif
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [CNT_W-1:0] RST_LIMIT = CNT_W'(DEFAULT_LIMIT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0]    count_q  [CHANNELS];
    logic [CNT_W-1:0]    count_d  [CHANNELS];
    logic [CNT_W-1:0]    active_q [CHANNELS];
    logic [CNT_W-1:0]    active_d [CHANNELS];
    logic [CNT_W-1:0]    shadow_q [CHANNELS];
    logic [CNT_W-1:0]    shadow_d [CHANNELS];
    logic [CNT_W-1:0]    lim_s    [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] pending_d;
    logic [CHANNELS-1:0] clkout_q;
    logic [CHANNELS-1:0] clkout_d;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic [CHANNELS-1:0] wrap_s;
    logic [CHANNELS-1:0] hit_s;
    logic                cfg_valid_s;
    logic                sync_s;

`ifdef CLKDIV_SYNC_EN
    assign sync_s = sync_restart;
`else
    assign sync_s = 1'b0;
`endif

    // Writes aimed past the last channel are dropped.
    assign cfg_valid_s = cfg_we && (int'(cfg_ch) < CHANNELS);

    // Per channel: effective limit (0 acts as 1), wrap condition and write target.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            lim_s[i]  = (active_q[i] == '0) ? ONE : active_q[i];
            // >= also catches a count left above a freshly loaded smaller limit.
            wrap_s[i] = clken[i] && (count_q[i] >= (lim_s[i] - ONE));
            hit_s[i]  = cfg_valid_s && (cfg_ch == CH_W'(i));
        end
    end

    // Next-state for counters, limits, shadow handoff and outputs.
    always_comb begin
        count_d   = count_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clkout_d  = clkout_q;
        tick_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync_s) begin
                // Phase restart: realign every channel and flush a waiting limit.
                count_d[i]   = '0;
                clkout_d[i]  = 1'b0;
                pending_d[i] = 1'b0;
                if (pending_q[i]) begin
                    active_d[i] = shadow_q[i];
                end else begin
                    active_d[i] = active_q[i];
                end
            end else begin
                if (wrap_s[i]) begin
                    count_d[i]  = '0;
                    clkout_d[i] = ~clkout_q[i];
                    tick_d[i]   = 1'b1;
                end else if (clken[i]) begin
                    count_d[i] = count_q[i] + ONE;
                end else begin
                    count_d[i] = count_q[i];
                end

                if (hit_s[i]) begin
                    if (!clken[i] || wrap_s[i]) begin
                        // No half-period in flight: load directly.
                        active_d[i]  = cfg_limit;
                        pending_d[i] = 1'b0;
                    end else begin
                        shadow_d[i]  = cfg_limit;
                        pending_d[i] = 1'b1;
                    end
                end else if (pending_q[i] && (!clken[i] || wrap_s[i])) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end else begin
                    active_d[i]  = active_q[i];
                    pending_d[i] = pending_q[i];
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= '0;
                active_q[i] <= RST_LIMIT;
                shadow_q[i] <= RST_LIMIT;
            end
            pending_q <= '0;
            clkout_q  <= '0;
            tick_q    <= '0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
        end
    end

    assign clkout = clkout_q;
    assign tick   = tick_q;

endmodule
